// File: rtl/csa_sum_accumulator.sv
// csa_sum_accumulator: sums one frame of adder words, counts carries and words, emits one result per frame
module csa_sum_accumulator #(
   parameter int WIDTH   = 64,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_sum,
   input  logic               in_cout,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_acc,
   output logic [COUNT_W-1:0] out_carries,
   output logic [COUNT_W-1:0] out_words
);
   localparam logic ACCUM = 1'b0;
   localparam logic DONE  = 1'b1;
   localparam logic [COUNT_W-1:0] CMAX = '1;
   logic               state;
   logic               first;
   logic [WIDTH-1:0]   acc;
   logic [COUNT_W-1:0] carries;
   logic [COUNT_W-1:0] words;
   logic [WIDTH:0]     sum_ext;
   logic               ovf;
   logic [COUNT_W+1:0] car_sum;
   logic [WIDTH-1:0]   acc_nxt;
   logic [COUNT_W-1:0] car_nxt;
   logic [COUNT_W-1:0] words_nxt;
   logic               accept;
   assign in_ready  = state == ACCUM;
   assign out_valid = state == DONE;
   assign accept    = in_valid & in_ready;
   // the first word of a frame loads directly, so it can never overflow
   always_comb begin
      sum_ext   = {1'b0, acc} + {1'b0, in_sum};
      ovf       = ~first & sum_ext[WIDTH];
      acc_nxt   = first ? in_sum : sum_ext[WIDTH-1:0];
      car_sum   = {2'b00, carries} + (COUNT_W+2)'(in_cout) + (COUNT_W+2)'(ovf);
      car_nxt   = car_sum > {2'b00, CMAX} ? CMAX : car_sum[COUNT_W-1:0];
      words_nxt = words == CMAX ? words : words + COUNT_W'(1);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ACCUM;
         first       <= 1'b1;
         acc         <= '0;
         carries     <= '0;
         words       <= '0;
         out_acc     <= '0;
         out_carries <= '0;
         out_words   <= '0;
      end else if (accept) begin
         acc     <= acc_nxt;
         carries <= car_nxt;
         words   <= words_nxt;
         first   <= 1'b0;
         if (in_last) begin
            state       <= DONE;
            out_acc     <= acc_nxt;
            out_carries <= car_nxt;
            out_words   <= words_nxt;
         end
      end else if (state == DONE && out_ready) begin
         state   <= ACCUM;
         first   <= 1'b1;
         acc     <= '0;
         carries <= '0;
         words   <= '0;
      end
   end
endmodule

// File: tb/tb_csa_sum_accumulator.sv
// tb_csa_sum_accumulator: directed and random frames checked against a wide-arithmetic frame model
module tb_csa_sum_accumulator;
   logic        clk, rst, in_valid, in_ready, in_cout, in_last, out_valid, out_ready;
   logic [63:0] in_sum, out_acc;
   logic [7:0]  out_carries, out_words;
   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] fq[$];
   bit          cq[$];
   int          gq[$];
   csa_sum_accumulator #(.WIDTH(64), .COUNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .in_cout(in_cout), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_acc(out_acc), .out_carries(out_carries), .out_words(out_words)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic add(input logic [63:0] w, input bit c, input int g);
      fq.push_back(w);
      cq.push_back(c);
      gq.push_back(g);
   endtask
   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction
   // expected results: exact frame total in 128 bits; every wrap past 2^64 is one overflow carry
   task automatic run_frame(input int hold);
      logic [127:0] tot;
      int           cs;
      logic [63:0]  ea;
      logic [7:0]   ec, ew;
      tot = '0;
      cs  = 0;
      foreach (fq[i]) begin
         tot += {64'b0, fq[i]};
         cs  += int'(cq[i]);
      end
      cs += int'(tot[127:64]);
      ea = tot[63:0];
      ec = cs > 255 ? 8'hFF : 8'(cs);
      ew = fq.size() > 255 ? 8'hFF : 8'(fq.size());
      foreach (fq[i]) begin
         in_valid = 0;
         repeat (gq[i]) @(posedge clk) #1;
         in_valid = 1;
         in_sum   = fq[i];
         in_cout  = cq[i];
         in_last  = i == fq.size() - 1;
         if (i == 0 || gq[i] != 0) check("in_ready_accum", 64'(in_ready), 64'd1);
         @(posedge clk) #1;
      end
      in_valid = 0;
      in_last  = 0;
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_acc", out_acc, ea);
      check("out_carries", 64'(out_carries), 64'(ec));
      check("out_words", 64'(out_words), 64'(ew));
      check("in_ready_done", 64'(in_ready), 64'd0);
      for (int k = 0; k < hold; k++) begin
         in_valid = 1;
         in_sum   = rnd64();
         in_cout  = 1;
         in_last  = 1;
         @(posedge clk) #1;
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_acc", out_acc, ea);
         check("hold_carries", 64'(out_carries), 64'(ec));
         check("hold_words", 64'(out_words), 64'(ew));
         check("hold_ready", 64'(in_ready), 64'd0);
      end
      in_valid  = 0;
      in_last   = 0;
      out_ready = 1;
      @(posedge clk) #1;
      out_ready = 0;
      check("release_valid", 64'(out_valid), 64'd0);
      check("release_ready", 64'(in_ready), 64'd1);
      fq.delete();
      cq.delete();
      gq.delete();
   endtask
   initial begin
      rst = 1; in_valid = 0; in_sum = '0; in_cout = 0; in_last = 0; out_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_acc", out_acc, 64'd0);
      check("rst_carries", 64'(out_carries), 64'd0);
      check("rst_words", 64'(out_words), 64'd0);
      rst = 0;
      @(posedge clk) #1;
      add(64'hAAAA_AAAA_AAAA_AAAA, 1, 0);
      run_frame(0);
      add(64'hAAAA_AAAA_AAAA_AAAA, 0, 1);
      add(64'hAAAA_AAAA_AAAA_AAAA, 0, 0);
      run_frame(5);
      for (int i = 0; i < 300; i++) add(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      run_frame(1);
      in_valid = 1;
      in_last  = 0;
      for (int i = 0; i < 3; i++) begin
         in_sum  = rnd64();
         in_cout = 1;
         @(posedge clk) #1;
      end
      in_valid = 0;
      rst = 1;
      @(posedge clk) #1;
      rst = 0;
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_ready", 64'(in_ready), 64'd1);
      check("midrst_words", 64'(out_words), 64'd0);
      check("midrst_carries", 64'(out_carries), 64'd0);
      add(64'h1, 0, 0);
      run_frame(0);
      add(64'h10, 0, 0);
      add(64'h20, 0, 4);
      run_frame(2);
      for (int f = 0; f < 40; f++) begin
         int n;
         n = f == 20 ? 260 : int'($urandom_range(1, 8));
         for (int i = 0; i < n; i++)
            add($urandom_range(0, 3) == 0 ? 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)) : rnd64(),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
         run_frame(int'($urandom_range(0, 3)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/csa_sum_accumulator.md
Name: csa_sum_accumulator

Overview:
- Stage directly downstream of the 64-bit carry-select adder (csa).
- Consumes a stream of adder results (sum plus carry-out) and accumulates one frame of words into a running 64-bit total.
- Counts carries from the incoming cout bits and from the accumulator's own overflow, and counts words per frame.
- Presents one registered result per frame over a valid/ready handshake.

Parameters:
- WIDTH, 64, data width of in_sum and out_acc.
- COUNT_W, 8, width of the word and carry counters (both saturating).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  in_sum/in_cout/in_last valid this cycle
- in_ready  output  1  block can accept an input word
- in_sum  input  WIDTH  adder sum word
- in_cout  input  1  adder carry-out accompanying in_sum
- in_last  input  1  marks the final word of a frame
- out_valid  output  1  frame result available
- out_ready  input  1  consumer accepts result
- out_acc  output  WIDTH  modulo-2^WIDTH sum of all frame words
- out_carries  output  COUNT_W  in_cout count plus accumulator overflow count, saturating
- out_words  output  COUNT_W  number of words in frame, saturating

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset (sampled on clk rising edge, rst=1) clears:
  - out_valid=0, out_acc=0, out_carries=0, out_words=0
  - internal acc, carry and word counters = 0
  - state = ACCUM, first-word flag = 1
- Reset has priority over all other activity. Reset mid-frame discards the partial frame; no output is produced for it.
- State machine:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Input handshake: a word is accepted when in_valid & in_ready at a clk edge. in_ready is purely registered-state derived (= state==ACCUM) and never depends on in_valid.
- Accumulate on accept:
  - sum_ext = {1'b0,acc} + {1'b0,in_sum}, computed at WIDTH+1 bits.
  - If first-word flag = 1, acc loads in_sum directly and no overflow is counted.
  - Otherwise acc <= sum_ext[WIDTH-1:0] and ovf = sum_ext[WIDTH].
  - Carry counter += in_cout + ovf (0, 1 or 2), saturating at 2^COUNT_W-1.
  - Word counter += 1, saturating at 2^COUNT_W-1.
  - First-word flag cleared.
- in_last on an accepted word:
  - The same edge updates acc/counters and loads out_acc/out_carries/out_words with the post-update values.
  - State -> DONE; out_valid rises the cycle after the accepting edge (latency 1).
- Output handshake:
  - In DONE, out_valid and all out_* fields are held stable until out_valid & out_ready.
  - On that edge: state -> ACCUM, out_valid -> 0, internal acc/counters cleared, first-word flag set.
  - out_* data keeps its last value (don't-care while out_valid=0).
  - Minimum one bubble cycle between the last word of one frame and the first word of the next.
- in_valid=0 cycles in ACCUM: no state change; gaps inside a frame are allowed.
- in_valid with in_ready=0 (DONE): the input is ignored; the upstream stage must hold it.
- No combinational path from any input to any output.

Test Plan:
- Single-word frame: in_sum=0xAAAA_AAAA_AAAA_AAAA, in_cout=1, in_last=1 -> one cycle later out_valid=1, out_acc=0xAAAA_AAAA_AAAA_AAAA, out_carries=1, out_words=1; in_ready=0 until out_ready.
- Two-word frame: 0xAAAA_AAAA_AAAA_AAAA twice, cout=0, last on the second -> out_acc=0x5555_5555_5555_5554, out_carries=1 (overflow), out_words=2.
- Backpressure: hold out_ready=0 for 5 cycles after the result -> out_valid=1 and out_* stable throughout, in_ready=0, offered inputs ignored; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Saturation: 300 words of 0xFFFF_FFFF_FFFF_FFFF, cout=1, last on the 300th -> out_acc=0xFFFF_FFFF_FFFF_FED4, out_carries=255, out_words=255.
- Reset mid-frame: accept 3 words, assert rst for one cycle -> out_valid=0, counters cleared; next frame single word 0x1, cout=0, last -> out_acc=0x1, out_carries=0, out_words=1.
- Idle gaps: 2-word frame 0x10 and 0x20 with 4 in_valid=0 cycles between them -> out_acc=0x30, out_words=2, out_carries=0.
